// File: rtl/hack_kbd_pkg.sv
// Shared constants for the Hack keyboard block: Hack key codes, PS/2 prefix bytes,
// receiver states and the scan-code set 2 to Hack key-code translation.
package hack_kbd_pkg;

    localparam logic [15:0] KEY_NEWLINE   = 16'd128;
    localparam logic [15:0] KEY_BACKSPACE = 16'd129;
    localparam logic [15:0] KEY_LEFT      = 16'd130;
    localparam logic [15:0] KEY_UP        = 16'd131;
    localparam logic [15:0] KEY_RIGHT     = 16'd132;
    localparam logic [15:0] KEY_DOWN      = 16'd133;
    localparam logic [15:0] KEY_HOME      = 16'd134;
    localparam logic [15:0] KEY_END       = 16'd135;
    localparam logic [15:0] KEY_PGUP      = 16'd136;
    localparam logic [15:0] KEY_PGDN      = 16'd137;
    localparam logic [15:0] KEY_INSERT    = 16'd138;
    localparam logic [15:0] KEY_DELETE    = 16'd139;
    localparam logic [15:0] KEY_ESC       = 16'd140;
    localparam logic [15:0] KEY_F1        = 16'd141;
    localparam logic [15:0] KEY_F12       = 16'd152;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Keypad digits share the digit codes; the E0-prefixed nav block has its own codes.
    function automatic logic [15:0] ps2_xlate(input logic [7:0] sc, input logic ext);
        logic [15:0] code;
        code = 16'd0;
        if (ext) begin
            case (sc)
                8'h6B: code = KEY_LEFT;
                8'h75: code = KEY_UP;
                8'h74: code = KEY_RIGHT;
                8'h72: code = KEY_DOWN;
                8'h6C: code = KEY_HOME;
                8'h69: code = KEY_END;
                8'h7D: code = KEY_PGUP;
                8'h7A: code = KEY_PGDN;
                8'h70: code = KEY_INSERT;
                8'h71: code = KEY_DELETE;
                8'h5A: code = KEY_NEWLINE;
                default: code = 16'd0;
            endcase
        end else begin
            case (sc)
                8'h1C: code = 16'd65;  8'h32: code = 16'd66;  8'h21: code = 16'd67;
                8'h23: code = 16'd68;  8'h24: code = 16'd69;  8'h2B: code = 16'd70;
                8'h34: code = 16'd71;  8'h33: code = 16'd72;  8'h43: code = 16'd73;
                8'h3B: code = 16'd74;  8'h42: code = 16'd75;  8'h4B: code = 16'd76;
                8'h3A: code = 16'd77;  8'h31: code = 16'd78;  8'h44: code = 16'd79;
                8'h4D: code = 16'd80;  8'h15: code = 16'd81;  8'h2D: code = 16'd82;
                8'h1B: code = 16'd83;  8'h2C: code = 16'd84;  8'h3C: code = 16'd85;
                8'h2A: code = 16'd86;  8'h1D: code = 16'd87;  8'h22: code = 16'd88;
                8'h35: code = 16'd89;  8'h1A: code = 16'd90;
                8'h45, 8'h70: code = 16'd48;  8'h16, 8'h69: code = 16'd49;
                8'h1E, 8'h72: code = 16'd50;  8'h26, 8'h7A: code = 16'd51;
                8'h25, 8'h6B: code = 16'd52;  8'h2E, 8'h73: code = 16'd53;
                8'h36, 8'h74: code = 16'd54;  8'h3D, 8'h6C: code = 16'd55;
                8'h3E, 8'h75: code = 16'd56;  8'h46, 8'h7D: code = 16'd57;
                8'h29: code = 16'd32;
                8'h5A: code = KEY_NEWLINE;
                8'h66: code = KEY_BACKSPACE;
                8'h76: code = KEY_ESC;
                8'h05: code = KEY_F1;      8'h06: code = KEY_F1 + 16'd1;
                8'h04: code = KEY_F1 + 16'd2;  8'h0C: code = KEY_F1 + 16'd3;
                8'h03: code = KEY_F1 + 16'd4;  8'h0B: code = KEY_F1 + 16'd5;
                8'h83: code = KEY_F1 + 16'd6;  8'h0A: code = KEY_F1 + 16'd7;
                8'h01: code = KEY_F1 + 16'd8;  8'h09: code = KEY_F1 + 16'd9;
                8'h78: code = KEY_F1 + 16'd10; 8'h07: code = KEY_F12;
                default: code = 16'd0;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/hack_kbd_ps2_rx.sv
// PS/2 frame receiver: input synchronizers, clock fall detect, 11-bit frame FSM.
// Optional mid-frame watchdog enabled by defining PS2_TIMEOUT_EN.
module ps2_rx
    import hack_kbd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       timeout_o
);

    if (SYNC_STAGES < 2 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("ps2_rx: SYNC_STAGES and TIMEOUT_CYC must both be at least 2");
    end

    logic [SYNC_STAGES-1:0] clk_sync_reg, clk_sync_next;
    logic [SYNC_STAGES-1:0] data_sync_reg, data_sync_next;
    logic                   clk_prev_reg;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign clk_sync_next[gi]  = ps2_clk_i;
            assign data_sync_next[gi] = ps2_data_i;
        end else begin : g_chain
            assign clk_sync_next[gi]  = clk_sync_reg[gi-1];
            assign data_sync_next[gi] = data_sync_reg[gi-1];
        end
    end

    logic ps2_clk_s, ps2_data_s, fall;
    assign ps2_clk_s  = clk_sync_reg[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_reg[SYNC_STAGES-1];
    assign fall       = clk_prev_reg & ~ps2_clk_s;

    rx_state_t  state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic       parity_reg, parity_next;
    logic       valid_reg, valid_next;
    logic       err_reg, err_next;
    logic       timeout_reg;
    logic       timeout_hit;

`ifdef PS2_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] to_cnt_reg;

    // Counts idle cycles since the last fall; only meaningful inside a frame.
    assign timeout_hit = (state_reg != RX_IDLE) && !fall
                         && (to_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            to_cnt_reg <= '0;
        end else if (fall || state_reg == RX_IDLE || timeout_hit) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        if (fall) begin
            case (state_reg)
                RX_IDLE: begin
                    if (!ps2_data_s) begin
                        state_next   = RX_DATA;
                        bit_cnt_next = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_next   = {ps2_data_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) state_next = RX_PARITY;
                end
                RX_PARITY: begin
                    parity_next = ps2_data_s;
                    state_next  = RX_STOP;
                end
                RX_STOP: begin
                    // Odd parity across data+parity, and a high stop bit.
                    if ((^{shift_reg, parity_reg}) && ps2_data_s) valid_next = 1'b1;
                    else                                          err_next   = 1'b1;
                    state_next = RX_IDLE;
                end
                default: state_next = RX_IDLE;
            endcase
        end else if (timeout_hit) begin
            state_next = RX_IDLE;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
            clk_prev_reg  <= 1'b1;
            state_reg     <= RX_IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            parity_reg    <= 1'b0;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            clk_sync_reg  <= clk_sync_next;
            data_sync_reg <= data_sync_next;
            clk_prev_reg  <= ps2_clk_s;
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            parity_reg    <= parity_next;
            valid_reg     <= valid_next;
            err_reg       <= err_next;
            timeout_reg   <= timeout_hit;
        end
    end

    assign byte_o       = shift_reg;
    assign byte_valid_o = valid_reg;
    assign frame_err_o  = err_reg;
    assign timeout_o    = timeout_reg;

endmodule

// File: rtl/hack_kbd_ps2.sv
// Hack KBD source: decodes E0/F0 prefixed PS/2 bytes into the held-key register.
// Define PS2_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYC idle cycles.
module hack_kbd_ps2
    import hack_kbd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [15:0] kbd_data_o,
    output logic        key_evt_o,
    output logic        frame_err_o
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_timeout;

    ps2_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (frame_err_o),
        .timeout_o   (rx_timeout)
    );

    logic        ext_reg, ext_next;
    logic        brk_reg, brk_next;
    logic [15:0] kbd_reg, kbd_next;
    logic        evt_reg;
    logic [15:0] code;

    assign code = ps2_xlate(rx_byte, ext_reg);

    always_comb begin
        ext_next = ext_reg;
        brk_next = brk_reg;
        kbd_next = kbd_reg;
        if (rx_timeout) begin
            ext_next = 1'b0;
            brk_next = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext_next = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_next = 1'b1;
            end else begin
                // Only releasing the currently held key clears it; last make wins.
                if (brk_reg) begin
                    if (code != 16'd0 && code == kbd_reg) kbd_next = 16'd0;
                end else if (code != 16'd0) begin
                    kbd_next = code;
                end
                ext_next = 1'b0;
                brk_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
            kbd_reg <= 16'd0;
            evt_reg <= 1'b0;
        end else begin
            ext_reg <= ext_next;
            brk_reg <= brk_next;
            kbd_reg <= kbd_next;
            evt_reg <= (kbd_next != kbd_reg);
        end
    end

    assign kbd_data_o = kbd_reg;
    assign key_evt_o  = evt_reg;

endmodule
